// File: rtl/instr_fetch_unit.sv
// Instruction fetch unit: issues word fetches, buffers in-order responses with their PCs in a prefetch FIFO.
// Optional feature macro IFU_STALL_CNT_EN adds the stall_cnt[15:0] output.
module instr_fetch_unit #(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int          FIFO_DEPTH = 4
) (
    input  logic        clk,
    input  logic        reset,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_gnt,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        instr_valid,
    input  logic        instr_ready,
    output logic [31:0] instr_out,
    output logic [31:0] instr_pc
`ifdef IFU_STALL_CNT_EN
    ,
    output logic [15:0] stall_cnt
`endif
);

    localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CW = AW + 1;
    localparam int SW = CW + 2;

    logic [31:0]   fetch_pc;
    logic [31:0]   resp_pc;
    logic [31:0]   redirect_tgt;
    logic [CW-1:0] fifo_count;
    logic [CW-1:0] outstanding;
    logic [CW-1:0] drop_cnt;
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [63:0]   fifo_mem [FIFO_DEPTH];
    logic [SW-1:0] inflight;
    logic          grant;
    logic          keep;
    logic          drop;
    logic          pop;

    // Handshakes: a transfer happens on a cycle where valid (req) and ready (gnt) are both high;
    // imem_rvalid is an unconditional in-order response, one per earlier grant.
    assign redirect_tgt = redirect_pc & 32'hFFFF_FFFC;
    assign imem_addr    = fetch_pc & 32'hFFFF_FFFC;
    assign inflight     = SW'(fifo_count) + SW'(outstanding) + SW'(drop_cnt);
    assign imem_req     = reset && !redirect_valid && (inflight < SW'(FIFO_DEPTH));
    assign grant        = imem_req && imem_gnt;
    assign keep         = imem_rvalid && !redirect_valid && (drop_cnt == '0);
    assign drop         = imem_rvalid && !redirect_valid && (drop_cnt != '0);
    assign instr_valid  = (fifo_count != '0);
    assign pop          = instr_valid && instr_ready;
    assign instr_pc     = instr_valid ? fifo_mem[rd_ptr][63:32] : 32'h0;
    assign instr_out    = instr_valid ? fifo_mem[rd_ptr][31:0]  : 32'h0;

    // resp_pc tracks the PC of the next kept response; kept responses follow the fetch order since the last redirect.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            fetch_pc <= RESET_PC;
            resp_pc  <= RESET_PC;
        end else if (redirect_valid) begin
            fetch_pc <= redirect_tgt;
            resp_pc  <= redirect_tgt;
        end else begin
            if (grant) fetch_pc <= fetch_pc + 32'd4;
            if (keep)  resp_pc  <= resp_pc + 32'd4;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            outstanding <= '0;
            drop_cnt    <= '0;
        end else if (redirect_valid) begin
            // A response landing this cycle retires one of the in-flight requests itself.
            outstanding <= '0;
            drop_cnt    <= drop_cnt + outstanding - CW'(imem_rvalid);
        end else begin
            case ({grant, keep})
                2'b10:   outstanding <= outstanding + CW'(1);
                2'b01:   outstanding <= outstanding - CW'(1);
                default: outstanding <= outstanding;
            endcase
            if (drop) drop_cnt <= drop_cnt - CW'(1);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            fifo_count <= '0;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
        end else if (redirect_valid) begin
            fifo_count <= '0;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
        end else begin
            if (keep) wr_ptr <= wr_ptr + AW'(1);
            if (pop)  rd_ptr <= rd_ptr + AW'(1);
            case ({keep, pop})
                2'b10:   fifo_count <= fifo_count + CW'(1);
                2'b01:   fifo_count <= fifo_count - CW'(1);
                default: fifo_count <= fifo_count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (keep) fifo_mem[wr_ptr] <= {resp_pc, imem_rdata};
    end

`ifdef IFU_STALL_CNT_EN
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            stall_cnt <= 16'h0000;
        end else if (instr_valid && !instr_ready && (stall_cnt != 16'hFFFF)) begin
            stall_cnt <= stall_cnt + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Self-checking bench for instr_fetch_unit: memory model with random latency, scoreboard of {pc, data} per grant.
module tb_instr_fetch_unit;

    localparam logic [31:0] RESET_PC   = 32'h0000_0000;
    localparam int          FIFO_DEPTH = 4;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt = 1'b0;
    logic        imem_rvalid = 1'b0;
    logic [31:0] imem_rdata = 32'h0;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = 32'h0;
    logic        instr_valid;
    logic        instr_ready = 1'b0;
    logic [31:0] instr_out;
    logic [31:0] instr_pc;
`ifdef IFU_STALL_CNT_EN
    logic [15:0] stall_cnt;
`endif

    instr_fetch_unit #(.RESET_PC(RESET_PC), .FIFO_DEPTH(FIFO_DEPTH)) dut (
        .clk            (clk),
        .reset          (reset),
        .imem_req       (imem_req),
        .imem_addr      (imem_addr),
        .imem_gnt       (imem_gnt),
        .imem_rvalid    (imem_rvalid),
        .imem_rdata     (imem_rdata),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .instr_valid    (instr_valid),
        .instr_ready    (instr_ready),
        .instr_out      (instr_out),
        .instr_pc       (instr_pc)
`ifdef IFU_STALL_CNT_EN
        ,
        .stall_cnt      (stall_cnt)
`endif
    );

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
        int          due;
    } pend_t;

    pend_t       pend_q[$];
    logic [63:0] exp_q[$];
    logic [31:0] grant_log[$];
    int          n_checks = 0;
    int          n_pass = 0;
    int          cyc = 0;
    int          grant_cnt = 0;
    int          lat_min = 1;
    int          lat_max = 1;
    logic [31:0] exp_addr = RESET_PC;
    logic        held_v = 1'b0;
    logic [63:0] held_val = 64'h0;
    logic [63:0] mon_e;
    logic [31:0] mon_d;
    pend_t       mem_p;

    // ---------------- memory model ----------------
    always @(posedge clk) begin
        #1;
        cyc = cyc + 1;
        if (!reset) begin
            pend_q.delete();
            imem_rvalid = 1'b0;
        end else if (pend_q.size() > 0 && pend_q[0].due <= cyc) begin
            mem_p = pend_q.pop_front();
            imem_rvalid = 1'b1;
            imem_rdata = mem_p.data;
        end else begin
            imem_rvalid = 1'b0;
            imem_rdata = $urandom();
        end
    end

    // ---------------- monitor / scoreboard ----------------
    always @(negedge clk) begin
        if (!reset) begin
            exp_q.delete();
            exp_addr = RESET_PC;
            held_v = 1'b0;
        end else begin
            if (instr_valid && instr_ready) begin
                n_checks++;
                if (exp_q.size() == 0) begin
                    $display("FAIL pop_unexpected: got pc=%h instr=%h, required no instruction", instr_pc, instr_out);
                end else begin
                    mon_e = exp_q.pop_front();
                    if ({instr_pc, instr_out} !== mon_e)
                        $display("FAIL pop_data: got pc=%h instr=%h, required pc=%h instr=%h",
                                 instr_pc, instr_out, mon_e[63:32], mon_e[31:0]);
                    else n_pass++;
                end
            end
            if (instr_valid && held_v) begin
                n_checks++;
                if ({instr_pc, instr_out} !== held_val)
                    $display("FAIL stall_hold: got %h, required %h", {instr_pc, instr_out}, held_val);
                else n_pass++;
            end
            held_v = instr_valid && !instr_ready && !redirect_valid;
            held_val = {instr_pc, instr_out};
            if (imem_req) begin
                n_checks++;
                if (imem_addr !== exp_addr)
                    $display("FAIL fetch_addr: got %h, required %h", imem_addr, exp_addr);
                else n_pass++;
            end
            if (redirect_valid) begin
                n_checks++;
                if (imem_req !== 1'b0)
                    $display("FAIL req_during_redirect: got %b, required 0", imem_req);
                else n_pass++;
                exp_q.delete();
                exp_addr = redirect_pc & 32'hFFFF_FFFC;
            end else if (imem_req && imem_gnt) begin
                mon_d = $urandom();
                pend_q.push_back('{imem_addr, mon_d, cyc + int'($urandom_range(lat_min, lat_max))});
                exp_q.push_back({imem_addr, mon_d});
                grant_log.push_back(imem_addr);
                exp_addr = exp_addr + 32'd4;
                grant_cnt++;
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic do_reset();
        reset = 1'b0;
        redirect_valid = 1'b0;
        step();
        step();
        grant_cnt = 0;
        grant_log.delete();
        reset = 1'b1;
    endtask

    task automatic wait_valid(input int budget, input string name);
        int k;
        k = 0;
        @(negedge clk);
        while (!instr_valid && k < budget) begin
            step();
            @(negedge clk);
            k++;
        end
        if (!instr_valid) begin
            n_checks++;
            $display("FAIL %s_timeout: instr_valid got 0 after %0d cycles, required 1", name, budget);
        end
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        reset = 1'b0;
        imem_gnt = 1'b1;
        instr_ready = 1'b1;
        step();
        @(negedge clk);
        n_checks++; if (imem_req !== 1'b0) $display("FAIL rst_req: got %b, required 0", imem_req); else n_pass++;
        n_checks++; if (instr_valid !== 1'b0) $display("FAIL rst_valid: got %b, required 0", instr_valid); else n_pass++;
        n_checks++; if (instr_out !== 32'h0) $display("FAIL rst_out: got %h, required 0", instr_out); else n_pass++;
        n_checks++; if (instr_pc !== 32'h0) $display("FAIL rst_pc: got %h, required 0", instr_pc); else n_pass++;
        n_checks++; if (imem_addr !== RESET_PC) $display("FAIL rst_addr: got %h, required %h", imem_addr, RESET_PC); else n_pass++;
`ifdef IFU_STALL_CNT_EN
        n_checks++; if (stall_cnt !== 16'h0) $display("FAIL rst_stall_cnt: got %0d, required 0", stall_cnt); else n_pass++;
`endif
    endtask

    task automatic test_stream();
        lat_min = 1; lat_max = 1;
        step();
        grant_cnt = 0;
        reset = 1'b1;
        @(negedge clk);
        n_checks++;
        if (imem_req !== 1'b1 || imem_addr !== RESET_PC)
            $display("FAIL stream_first_req: got req=%b addr=%h, required req=1 addr=%h", imem_req, imem_addr, RESET_PC);
        else n_pass++;
        step();
        @(negedge clk);
        n_checks++; if (instr_valid !== 1'b0) $display("FAIL stream_latency_early: got %b, required 0", instr_valid); else n_pass++;
        step();
        @(negedge clk);
        n_checks++;
        if (instr_valid !== 1'b1 || instr_pc !== RESET_PC)
            $display("FAIL stream_first_out: got valid=%b pc=%h, required valid=1 pc=%h", instr_valid, instr_pc, RESET_PC);
        else n_pass++;
        for (int i = 0; i < 12; i++) begin
            step();
            @(negedge clk);
            n_checks++;
            if (instr_valid !== 1'b1) $display("FAIL stream_continuous: cycle %0d got valid=%b, required 1", i, instr_valid);
            else n_pass++;
        end
    endtask

    task automatic test_backpressure();
        instr_ready = 1'b0;
        imem_gnt = 1'b1;
        lat_min = 1; lat_max = 1;
        do_reset();
        wait_valid(20, "bp_fill");
`ifdef IFU_STALL_CNT_EN
        for (int i = 0; i < 10; i++) begin
            step();
            @(negedge clk);
        end
        n_checks++; if (stall_cnt !== 16'd10) $display("FAIL stall_cnt: got %0d, required 10", stall_cnt); else n_pass++;
`endif
        repeat (8) step();
        @(negedge clk);
        n_checks++; if (grant_cnt !== 4) $display("FAIL bp_grants: got %0d, required 4", grant_cnt); else n_pass++;
        n_checks++; if (imem_req !== 1'b0) $display("FAIL bp_req_off: got %b, required 0", imem_req); else n_pass++;
        step();
        instr_ready = 1'b1;
        @(negedge clk);
        n_checks++; if (instr_pc !== 32'h0) $display("FAIL bp_drain_first: got %h, required 0", instr_pc); else n_pass++;
        for (int i = 0; i < 20 && grant_cnt <= 4; i++) step();
        n_checks++; if (grant_cnt <= 4) $display("FAIL bp_resume: got %0d grants, required more than 4", grant_cnt); else n_pass++;
    endtask

    task automatic test_redirect();
        instr_ready = 1'b1;
        imem_gnt = 1'b1;
        lat_min = 3; lat_max = 3;
        do_reset();
        step();
        step();
        n_checks++; if (grant_cnt !== 2) $display("FAIL redir_setup: got %0d grants, required 2", grant_cnt); else n_pass++;
        redirect_valid = 1'b1;
        redirect_pc = 32'h0000_0103;
        step();
        redirect_valid = 1'b0;
        @(negedge clk);
        n_checks++;
        if (imem_req !== 1'b1 || imem_addr !== 32'h0000_0100)
            $display("FAIL redir_addr: got req=%b addr=%h, required req=1 addr=00000100", imem_req, imem_addr);
        else n_pass++;
        wait_valid(20, "redir");
        n_checks++; if (instr_pc !== 32'h0000_0100) $display("FAIL redir_first_pc: got %h, required 00000100", instr_pc); else n_pass++;
        lat_min = 1; lat_max = 1;
    endtask

    task automatic test_redirect_collide();
        instr_ready = 1'b1;
        imem_gnt = 1'b1;
        lat_min = 1; lat_max = 1;
        do_reset();
        repeat (6) step();
        redirect_valid = 1'b1;
        redirect_pc = 32'h0000_0200;
        @(negedge clk);
        n_checks++; if (instr_valid !== 1'b1) $display("FAIL collide_valid: got %b, required 1", instr_valid); else n_pass++;
        step();
        redirect_valid = 1'b0;
        wait_valid(20, "collide");
        n_checks++; if (instr_pc !== 32'h0000_0200) $display("FAIL collide_first_pc: got %h, required 00000200", instr_pc); else n_pass++;
        repeat (4) step();
    endtask

    task automatic test_wrap();
        instr_ready = 1'b1;
        imem_gnt = 1'b1;
        grant_log.delete();
        redirect_valid = 1'b1;
        redirect_pc = 32'hFFFF_FFF8;
        step();
        redirect_valid = 1'b0;
        repeat (4) step();
        @(negedge clk);
        n_checks++;
        if (grant_log.size() < 3) $display("FAIL wrap_grants: got %0d grants, required at least 3", grant_log.size());
        else n_pass++;
        if (grant_log.size() >= 3) begin
            n_checks++; if (grant_log[0] !== 32'hFFFF_FFF8) $display("FAIL wrap_a0: got %h, required fffffff8", grant_log[0]); else n_pass++;
            n_checks++; if (grant_log[1] !== 32'hFFFF_FFFC) $display("FAIL wrap_a1: got %h, required fffffffc", grant_log[1]); else n_pass++;
            n_checks++; if (grant_log[2] !== 32'h0000_0000) $display("FAIL wrap_a2: got %h, required 00000000", grant_log[2]); else n_pass++;
        end
    endtask

    task automatic test_reset_mid();
        instr_ready = 1'b0;
        imem_gnt = 1'b1;
        lat_min = 1; lat_max = 1;
        do_reset();
        step();
        step();
        step();
        imem_gnt = 1'b0;
        step();
        step();
        @(negedge clk);
        n_checks++; if (grant_cnt !== 3) $display("FAIL rmid_setup: got %0d grants, required 3", grant_cnt); else n_pass++;
        n_checks++; if (instr_valid !== 1'b1) $display("FAIL rmid_filled: got %b, required 1", instr_valid); else n_pass++;
        step();
        reset = 1'b0;
        #1;
        n_checks++; if (instr_valid !== 1'b0) $display("FAIL rmid_valid: got %b, required 0", instr_valid); else n_pass++;
        n_checks++; if (instr_out !== 32'h0 || instr_pc !== 32'h0)
            $display("FAIL rmid_out: got pc=%h instr=%h, required 0/0", instr_pc, instr_out); else n_pass++;
        n_checks++; if (imem_req !== 1'b0) $display("FAIL rmid_req: got %b, required 0", imem_req); else n_pass++;
        step();
        step();
        reset = 1'b1;
        imem_gnt = 1'b1;
        instr_ready = 1'b1;
        @(negedge clk);
        n_checks++;
        if (imem_req !== 1'b1 || imem_addr !== RESET_PC)
            $display("FAIL rmid_restart: got req=%b addr=%h, required req=1 addr=%h", imem_req, imem_addr, RESET_PC);
        else n_pass++;
    endtask

    task automatic test_random();
        lat_min = 1; lat_max = 3;
        for (int i = 0; i < 400; i++) begin
            imem_gnt = ($urandom_range(0, 3) != 0);
            instr_ready = ($urandom_range(0, 3) != 0);
            redirect_valid = ($urandom_range(0, 15) == 0);
            redirect_pc = ($urandom_range(0, 1) == 0) ? $urandom() : (32'hFFFF_FFF0 | 32'($urandom_range(0, 15)));
            step();
        end
        redirect_valid = 1'b0;
        imem_gnt = 1'b0;
        instr_ready = 1'b1;
        for (int i = 0; i < 60 && (exp_q.size() != 0 || pend_q.size() != 0); i++) step();
        @(negedge clk);
        n_checks++; if (exp_q.size() != 0) $display("FAIL rand_drain: %0d entries left, required 0", exp_q.size()); else n_pass++;
        n_checks++; if (instr_valid !== 1'b0) $display("FAIL rand_empty: got valid=%b, required 0", instr_valid); else n_pass++;
    endtask

    // ---------------- sequence and report ----------------
    initial begin
        test_reset();
        test_stream();
        test_backpressure();
        test_redirect();
        test_redirect_collide();
        test_wrap();
        test_reset_mid();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $display("%0d/%0d checks passed", n_pass, n_checks + 1);
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/instr_fetch_unit.md
INSTR_FETCH_UNIT -- requirements
Module: instr_fetch_unit

Interface
REQ-001 SHALL provide parameter RESET_PC, default 32'h0000_0000, the first fetch address after reset.
REQ-002 SHALL provide parameter FIFO_DEPTH, default 4, the prefetch buffer entries; legal values are powers of two, 2 to 16.
REQ-003 SHALL have port clk  input  1  clock; all state updates on the rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port imem_req  output  1  fetch request valid.
REQ-006 SHALL have port imem_addr  output  32  fetch address, word aligned.
REQ-007 SHALL have port imem_gnt  input  1  request accepted when imem_req && imem_gnt.
REQ-008 SHALL have port imem_rvalid  input  1  in-order response valid, at least 1 cycle after its grant.
REQ-009 SHALL have port imem_rdata  input  32  response instruction word.
REQ-010 SHALL have port redirect_valid  input  1  pipeline branch/jump redirect.
REQ-011 SHALL have port redirect_pc  input  32  redirect target; bits [1:0] are ignored and treated as 0.
REQ-012 SHALL have port instr_valid  output  1  instruction available to the pipeline.
REQ-013 SHALL have port instr_ready  input  1  pipeline accepts; a pop occurs on instr_valid && instr_ready.
REQ-014 SHALL have port instr_out  output  32  instruction word (feeds the pipeline's instruction_in).
REQ-015 SHALL have port instr_pc  output  32  address of instr_out.

Function
REQ-016 SHALL hold a fetch PC register; imem_addr SHALL equal the fetch PC with bits [1:0] = 0.
REQ-017 SHALL drive imem_req = !redirect_valid && (fifo_count + outstanding + drop_cnt) < FIFO_DEPTH.
REQ-018 SHALL increment the fetch PC by 4 on each grant; 32'hFFFF_FFFC SHALL wrap to 32'h0000_0000.
REQ-019 SHALL increment outstanding on a grant and decrement it on a kept response; a simultaneous grant and kept response SHALL leave it unchanged.
REQ-020 SHALL write a non-dropped response into the FIFO as {pc, imem_rdata}, with pc taken in request order.
REQ-021 SHALL make a response written at edge N visible on instr_valid/instr_out/instr_pc in the cycle after edge N (1-cycle latency).
REQ-022 SHALL assert instr_valid iff the FIFO is non-empty; outputs SHALL hold stable while instr_valid && !instr_ready.
REQ-023 SHALL allow push and pop in the same cycle when the FIFO is full or empty-plus-push, leaving fifo_count correct.
REQ-024 SHALL never overflow the FIFO; the issue rule in REQ-017 guarantees a slot for every in-flight response.
REQ-025 On redirect_valid, the block SHALL load the fetch PC with {redirect_pc[31:2],2'b00}, flush the FIFO, add outstanding to drop_cnt, and clear outstanding.
REQ-026 SHALL discard (not write) each response while drop_cnt > 0 and decrement drop_cnt.
REQ-027 A response arriving in the same cycle as redirect_valid SHALL be discarded and SHALL not be counted into drop_cnt.
REQ-028 A pop in the same cycle as redirect_valid SHALL complete, and the FIFO SHALL then be empty.
REQ-029 The FIFO write pointer and read pointer SHALL wrap modulo FIFO_DEPTH.

Reset
REQ-030 While reset is low, the block SHALL hold fetch PC = RESET_PC, fifo_count = outstanding = drop_cnt = 0, and instr_valid = 0.
REQ-031 While reset is low, instr_out and instr_pc SHALL be 0 and imem_req SHALL be 0.
REQ-032 Reset asserted mid-operation SHALL abandon all in-flight requests; the memory side SHALL also be reset.

Configuration
REQ-033 With macro IFU_STALL_CNT_EN defined, the block SHALL add output stall_cnt[15:0].
REQ-034 stall_cnt SHALL count cycles with instr_valid && !instr_ready, saturate at 16'hFFFF, and reset to 0.
REQ-035 Without IFU_STALL_CNT_EN, the stall_cnt port and its logic SHALL be absent, with no other behaviour change.

Verification
REQ-036 Reset release, imem_gnt=1, 1-cycle response, instr_ready=1 -> addresses 0,4,8,... issue and instr_pc follows 1 cycle after each response with a continuous stream.
REQ-037 instr_ready=0 with FIFO_DEPTH=4 -> exactly 4 grants, then imem_req=0; raising instr_ready drains 0,4,8,C in order and fetching resumes.
REQ-038 Redirect to 32'h0000_0103 with 2 outstanding -> next request addr 32'h100; 2 late responses dropped; first instr_pc = 32'h100.
REQ-039 Redirect_pc set to 32'hFFFF_FFF8 -> fetches FFFF_FFF8, FFFF_FFFC, 0000_0000.
REQ-040 Assert reset mid-stream with FIFO holding 3 entries -> instr_valid=0 immediately; after release, first addr = RESET_PC.
REQ-041 With IFU_STALL_CNT_EN defined, hold instr_ready=0 for 10 cycles with FIFO non-empty -> stall_cnt = 10.
